// File: rtl/square_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | square_accumulator_if : row input and digit output bundle of the         |
// |                         square accumulator                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface square_accumulator_if #(
   parameter int NUM_ELEMENTS = 62,
   parameter int BIT_LEN      = 18,
   parameter int WORD_LEN     = 17
);
   localparam int MUL_OUT_BIT_LEN = 2 * BIT_LEN;

   logic                                            row_valid;
   logic                                            row_ready;
   logic [NUM_ELEMENTS-1:0][MUL_OUT_BIT_LEN-1:0]    row_data;
   logic                                            out_valid;
   logic                                            out_ready;
   logic [WORD_LEN-1:0]                             out_digit;
   logic                                            out_last;
   logic                                            overflow;
   logic                                            busy;

   modport master (
      output row_valid, row_data, out_ready,
      input  row_ready, out_valid, out_digit, out_last, overflow, busy
   );

   modport slave (
      input  row_valid, row_data, out_ready,
      output row_ready, out_valid, out_digit, out_last, overflow, busy
   );
endinterface
`default_nettype wire

// File: rtl/square_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | square_accumulator : sums product rows into shifted columns, then emits  |
// |                      the normalized square one digit at a time           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module square_accumulator #(
   parameter int NUM_ELEMENTS = 62,
   parameter int BIT_LEN      = 18,
   parameter int WORD_LEN     = 17
) (
   input  wire logic            clk,
   input  wire logic            reset,
   square_accumulator_if.slave  bus
);
   localparam int MUL_OUT_BIT_LEN = 2 * BIT_LEN;
   localparam int ACC_BIT_LEN     = MUL_OUT_BIT_LEN + $clog2(NUM_ELEMENTS);
   localparam int CARRY_BIT_LEN   = ACC_BIT_LEN - WORD_LEN + 1;
   localparam int SUM_BIT_LEN     = ACC_BIT_LEN + 1;
   localparam int NUM_COEF        = 2 * NUM_ELEMENTS;
   localparam int ROW_CNT_W       = $clog2(NUM_ELEMENTS + 1);
   localparam int DIG_CNT_W       = $clog2(NUM_COEF + 1);

   localparam logic [ROW_CNT_W-1:0] c_last_row     = ROW_CNT_W'(NUM_ELEMENTS - 1);
   localparam logic [DIG_CNT_W-1:0] c_pre_last_dig = DIG_CNT_W'(NUM_COEF - 2);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_EMIT  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t                    r_state;
   logic [ACC_BIT_LEN-1:0]    r_coef [NUM_COEF];
   logic [ROW_CNT_W-1:0]      r_row;
   logic [DIG_CNT_W-1:0]      r_dig;
   logic [CARRY_BIT_LEN-1:0]  r_carry;
   logic                      r_row_ready;
   logic                      r_out_valid;
   logic                      r_out_last;
   logic                      r_overflow;
   logic                      r_busy;

   logic                      w_row_hs;
   logic                      w_out_hs;
   logic [SUM_BIT_LEN-1:0]    w_sum;
   logic [CARRY_BIT_LEN-1:0]  w_next_carry;

   assign w_row_hs     = bus.row_valid && r_row_ready;
   assign w_out_hs     = r_out_valid && bus.out_ready;
   // Full-width sum so the carry keeps every bit above the digit.
   assign w_sum        = SUM_BIT_LEN'(r_coef[r_dig]) + SUM_BIT_LEN'(r_carry);
   assign w_next_carry = w_sum[SUM_BIT_LEN-1:WORD_LEN];

   assign bus.row_ready = r_row_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_digit = r_out_valid ? w_sum[WORD_LEN-1:0] : '0;
   assign bus.out_last  = r_out_last;
   assign bus.overflow  = r_overflow;
   assign bus.busy      = r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_ACCUM;
         for (int k = 0; k < NUM_COEF; k++) r_coef[k] <= '0;
         r_row       <= '0;
         r_dig       <= '0;
         r_carry     <= '0;
         r_overflow  <= 1'b0;
         r_row_ready <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_row_hs) begin
                  // Row r lands on columns r..r+NUM_ELEMENTS-1.
                  for (int j = 0; j < NUM_ELEMENTS; j++) begin
                     r_coef[DIG_CNT_W'(r_row) + DIG_CNT_W'(j)] <=
                        r_coef[DIG_CNT_W'(r_row) + DIG_CNT_W'(j)] +
                        ACC_BIT_LEN'(bus.row_data[j]);
                  end
                  r_row <= r_row + 1'b1;
                  if (r_row == c_last_row) begin
                     r_state     <= ST_EMIT;
                     r_row_ready <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_last  <= 1'b0;
                     r_busy      <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               if (w_out_hs) begin
                  r_carry    <= w_next_carry;
                  r_dig      <= r_dig + 1'b1;
                  r_out_last <= (r_dig == c_pre_last_dig);
                  if (r_out_last) begin
                     r_overflow  <= |w_next_carry;
                     r_state     <= ST_CLEAR;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                  end
               end
            end
            ST_CLEAR: begin
               for (int k = 0; k < NUM_COEF; k++) r_coef[k] <= '0;
               r_row       <= '0;
               r_dig       <= '0;
               r_carry     <= '0;
               r_overflow  <= 1'b0;
               r_state     <= ST_ACCUM;
               r_row_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state     <= ST_ACCUM;
               r_row_ready <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_square_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_square_accumulator : directed scenarios with a digit scoreboard       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_square_accumulator;
   localparam int NUM_ELEMENTS = 62;
   localparam int BIT_LEN      = 18;
   localparam int WORD_LEN     = 17;
   localparam int NUM_COEF     = 2 * NUM_ELEMENTS;

   localparam int K_ZERO = 0;
   localparam int K_UNIT = 1;
   localparam int K_MAX  = 2;
   localparam int K_OVF  = 3;

   typedef logic [NUM_ELEMENTS-1:0][2*BIT_LEN-1:0] row_t;
   typedef struct packed {
      logic                chk;
      logic                last;
      logic [WORD_LEN-1:0] digit;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   exp_t exp_q[$];
   logic ovf_q[$];
   logic post_clear;
   int   mon_idx;

   square_accumulator_if #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .BIT_LEN      (BIT_LEN),
      .WORD_LEN     (WORD_LEN)
   ) bus ();

   square_accumulator #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .BIT_LEN      (BIT_LEN),
      .WORD_LEN     (WORD_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx,
                        input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=0x%0h want=0x%0h", name, idx, act, exp);
      end
   endtask

   function automatic row_t row_for(input int kind, input int r);
      row_t row;
      row = '0;
      for (int j = 0; j < NUM_ELEMENTS; j++) begin
         case (kind)
            K_UNIT:  if (r == 0 && j == 0) row[j] = 36'd1;
            K_MAX:   row[j] = 36'h3FFFC0001;
            K_OVF:   if (r == NUM_ELEMENTS - 1) row[j] = 36'hFFFFFFFFF;
            default: row[j] = '0;
         endcase
      end
      return row;
   endfunction

   // Hand-derived digit patterns for each scenario.
   task automatic push_expected(input int kind);
      exp_t e;
      for (int d = 0; d < NUM_COEF; d++) begin
         e.chk  = 1'b1;
         e.last = (d == NUM_COEF - 1);
         case (kind)
            K_UNIT: e.digit = (d == 0) ? 17'd1 : 17'd0;
            K_MAX: begin
               if (d == 0)       e.digit = 17'h00001;
               else if (d < 62)  e.digit = 17'h00000;
               else if (d == 62) e.digit = 17'h1FFFE;
               else              e.digit = 17'h1FFFF;
            end
            K_OVF: begin
               if (d < 61)       e.digit = 17'h00000;
               else if (d == 61) e.digit = 17'h1FFFF;
               else begin
                  e.digit = 17'h00000;
                  e.chk   = 1'b0;
               end
            end
            default: e.digit = 17'h00000;
         endcase
         exp_q.push_back(e);
      end
      ovf_q.push_back(kind == K_OVF);
   endtask

   task automatic send_rows(input int kind, input int count);
      int guard;
      for (int r = 0; r < count; r++) begin
         bus.row_valid = 1'b1;
         bus.row_data  = row_for(kind, r);
         guard = 0;
         while (!bus.row_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
         if (!bus.row_ready) begin
            total++; bad++;
            $display("FAIL row_ready_timeout row=%0d", r);
            return;
         end
         @(posedge clk); #1;
      end
      bus.row_valid = 1'b0;
   endtask

   task automatic drain(input int stall_at, input logic junk_rows);
      int   n;
      int   stall;
      int   guard;
      logic hs;
      n = 0; stall = 0; guard = 0;
      if (junk_rows) begin
         bus.row_valid = 1'b1;
         bus.row_data  = '1;
      end
      while (n < NUM_COEF && guard < 1000) begin
         if (n == stall_at && stall < 5) begin
            bus.out_ready = 1'b0;
            stall++;
         end else begin
            bus.out_ready = 1'b1;
         end
         hs = bus.out_valid && bus.out_ready;
         @(posedge clk); #1;
         if (hs) n++;
         guard++;
      end
      bus.row_valid = 1'b0;
      bus.out_ready = 1'b1;
      if (n != NUM_COEF) begin
         total++; bad++;
         $display("FAIL drain_timeout got=%0d want=%0d", n, NUM_COEF);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int kind, input int stall_at, input logic junk_rows);
      push_expected(kind);
      send_rows(kind, NUM_ELEMENTS);
      drain(stall_at, junk_rows);
   endtask

   task automatic check_idle(input int tag);
      check("idle_row_ready", tag, 64'(bus.row_ready), 64'd1);
      check("idle_out_valid", tag, 64'(bus.out_valid), 64'd0);
      check("idle_out_last",  tag, 64'(bus.out_last),  64'd0);
      check("idle_busy",      tag, 64'(bus.busy),      64'd0);
      check("idle_out_digit", tag, 64'(bus.out_digit), 64'd0);
      check("idle_overflow",  tag, 64'(bus.overflow),  64'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic eo;
      if (!reset) begin
         if (post_clear) begin
            post_clear = 1'b0;
            check("post_clear_row_ready", mon_idx, 64'(bus.row_ready), 64'd1);
            check("post_clear_overflow",  mon_idx, 64'(bus.overflow),  64'd0);
         end
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_digit got=0x%0h want=none", bus.out_digit);
            end else if (bus.out_ready) begin
               e = exp_q.pop_front();
               if (e.chk) check("digit", mon_idx, 64'(bus.out_digit), 64'(e.digit));
               check("out_last", mon_idx, 64'(bus.out_last), 64'(e.last));
               mon_idx = e.last ? 0 : mon_idx + 1;
            end else begin
               e = exp_q[0];
               if (e.chk) check("held_digit", mon_idx, 64'(bus.out_digit), 64'(e.digit));
            end
         end else if (bus.busy && !bus.row_ready) begin
            if (ovf_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_clear got=1 want=0");
            end else begin
               eo = ovf_q.pop_front();
               check("overflow", mon_idx, 64'(bus.overflow), 64'(eo));
            end
            post_clear = 1'b1;
         end
      end
   end

   initial begin
      total         = 0;
      bad           = 0;
      post_clear    = 1'b0;
      mon_idx       = 0;
      reset         = 1'b1;
      bus.row_valid = 1'b0;
      bus.row_data  = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check_idle(0);

      run_op(K_ZERO, -1, 1'b0);
      run_op(K_UNIT, -1, 1'b0);
      run_op(K_MAX,  62, 1'b1);
      run_op(K_OVF,  -1, 1'b0);
      run_op(K_UNIT, -1, 1'b0);

      // Abandon a partly accumulated operand; nothing from it may appear.
      send_rows(K_MAX, 10);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      check_idle(1);
      run_op(K_UNIT, -1, 1'b0);

      repeat (5) @(posedge clk);
      check("queue_empty", 0, 64'(exp_q.size()), 64'd0);
      check("ovf_queue_empty", 0, 64'(ovf_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
